gmii_tx_framer: RTL and testbench
=================================

GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 SHALL have parameter MIN_PAYLOAD, default 60: minimum bytes before FCS; shorter frames are zero-padded.
REQ-002 SHALL have parameter IFG_CYCLES, default 12: minimum idle cycles between frames.
REQ-003 SHALL have port clk_8  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset_8  input  1  synchronous, active-high reset.
REQ-005 SHALL have port axis_tdata_in  input  8  payload byte from the 32-to-8 width converter.
REQ-006 SHALL have port axis_tvalid_in  input  1  payload byte valid.
REQ-007 SHALL have port axis_tlast_in  input  1  last payload byte of the frame.
REQ-008 SHALL have port axis_tready_out  output  1  byte accepted when high together with axis_tvalid_in.
REQ-009 SHALL have port gmii_txd  output  8  transmit byte to the PHY.
REQ-010 SHALL have port gmii_tx_en  output  1  transmit enable.
REQ-011 SHALL have port gmii_tx_er  output  1  transmit error (frame abort).
REQ-012 SHALL have port frame_sent  output  1  one-cycle pulse per completed frame.
REQ-013 SHALL have port tx_underrun  output  1  one-cycle pulse per aborted frame.

Function
REQ-014 SHALL implement states IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG.
REQ-015 SHALL register gmii_txd, gmii_tx_en, gmii_tx_er, frame_sent and tx_underrun, so the byte chosen in state S appears on the cycle after S.
REQ-016 SHALL drive axis_tready_out combinationally high only in DATA and DRAIN.
REQ-017 SHALL move from IDLE to PRE when axis_tvalid_in=1 is sampled; it SHALL consume no byte in IDLE.
REQ-018 SHALL stay in PRE for 7 cycles, loading 0x55 each cycle, then spend 1 cycle in SFD loading 0xD5.
REQ-019 SHALL, in DATA, load each accepted byte with gmii_tx_en=1 and increment an 11-bit byte counter that saturates at 2047.
REQ-020 SHALL, on accepting a byte with axis_tlast_in=1, go to PAD if the count including that byte is below MIN_PAYLOAD, else go to FCS.
REQ-021 SHALL, in PAD, load 0x00 until the total payload equals MIN_PAYLOAD, then go to FCS.
REQ-022 SHALL compute CRC-32 over all data and pad bytes: reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at SFD, 8 bits per cycle.
REQ-023 SHALL, in FCS, load the bitwise complement of the CRC over 4 cycles, least-significant byte first.
REQ-024 SHALL pulse frame_sent on the cycle the final FCS byte is presented.
REQ-025 SHALL, in DATA with axis_tvalid_in=0 (underrun), load gmii_tx_en=1, gmii_tx_er=1 and gmii_txd=0x00 for one cycle, pulse tx_underrun, and go to DRAIN.
REQ-026 SHALL, in DRAIN, hold gmii_tx_en=0 and discard input bytes until a byte with tlast is accepted, then go to IFG.
REQ-027 SHALL, in IFG, hold gmii_tx_en=0 for IFG_CYCLES cycles counted from the first low cycle, then return to IDLE.
REQ-028 SHALL ignore axis_tvalid_in in IFG, so the next preamble never starts early.
REQ-029 SHALL produce exactly 8 + max(N, MIN_PAYLOAD) + 4 cycles of gmii_tx_en=1 for an N-byte frame without underrun.
REQ-030 SHALL, when an over-length frame saturates the counter, keep transmitting and compute the FCS normally.

Reset
REQ-031 SHALL, with reset_8=1 at a clock edge, enter IDLE and clear the byte counter, IFG counter and CRC register.
REQ-032 SHALL drive gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, frame_sent=0, tx_underrun=0 and axis_tready_out=0 on the cycle after reset is sampled.
REQ-033 SHALL, on reset mid-frame, truncate the frame without asserting gmii_tx_er.
REQ-034 SHALL treat the first frame after reset normally, with no IFG wait.

Verification
REQ-035 SHALL cover a 64-byte frame (bytes 0x00..0x3F, tvalid held high) -> 7x0x55, 0xD5, 64 bytes in order, 4 FCS bytes; gmii_tx_en high 76 cycles; CRC over data+FCS leaves residue 0xC704DD7B; one frame_sent pulse.
REQ-036 SHALL cover a 10-byte frame -> 50 bytes of 0x00 pad, then FCS; gmii_tx_en high 72 cycles; axis_tready_out high exactly 10 handshakes.
REQ-037 SHALL cover a 1-byte frame with tlast on the first byte -> 59 pad bytes; FCS matches a bench CRC over 60 bytes.
REQ-038 SHALL cover back-to-back 64-byte frames with tvalid held high -> gmii_tx_en low exactly 12 cycles between FCS byte 4 and the next 0x55.
REQ-039 SHALL cover tvalid dropping after byte 20 of a 40-byte frame -> one cycle of tx_en=1, tx_er=1, txd=0x00; tx_underrun pulses; remaining 20 bytes drained with tx_en=0; no frame_sent.
REQ-040 SHALL cover reset_8 asserted at byte 30 -> all outputs 0 on the next cycle; the following frame is correct per REQ-035.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: turns a byte stream into preamble + SFD + payload (padded) + CRC-32 FCS,
// enforces the inter-frame gap and aborts the frame with tx_er when the source underruns.
module gmii_tx_framer #(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_CYCLES  = 12
) (
    input  logic       clk_8,
    input  logic       reset_8,
    input  logic [7:0] axis_tdata_in,
    input  logic       axis_tvalid_in,
    input  logic       axis_tlast_in,
    output logic       axis_tready_out,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       frame_sent,
    output logic       tx_underrun
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [10:0] CNT_MAX  = 11'h7FF;
    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
    localparam logic [2:0]  PRE_LAST = 3'd6;
    // IDLE always adds one low cycle after IFG, so IFG itself lasts one cycle less
    localparam int          IFG_LAST_I = (IFG_CYCLES >= 2) ? (IFG_CYCLES - 2) : 0;
    localparam logic [15:0] IFG_LAST   = 16'(IFG_LAST_I);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        DRAIN,
        IFG
    } state_t;

    state_t      state_reg;
    logic [2:0]  pre_cnt_reg;
    logic [1:0]  fcs_idx_reg;
    logic [10:0] byte_cnt_reg;
    logic [15:0] ifg_cnt_reg;
    logic [31:0] crc_reg;

    logic [7:0]  txd_reg;
    logic        tx_en_reg;
    logic        tx_er_reg;
    logic        frame_sent_reg;
    logic        underrun_reg;

    logic [7:0]  crc_data;
    logic [31:0] crc_next;
    logic [10:0] cnt_inc;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign crc_data = (state_reg == PAD) ? 8'h00 : axis_tdata_in;
    assign crc_next = crc32_byte(crc_reg, crc_data);
    assign cnt_inc  = (byte_cnt_reg == CNT_MAX) ? CNT_MAX : byte_cnt_reg + 11'd1;

    assign axis_tready_out = (state_reg == DATA) || (state_reg == DRAIN);

    assign gmii_txd    = txd_reg;
    assign gmii_tx_en  = tx_en_reg;
    assign gmii_tx_er  = tx_er_reg;
    assign frame_sent  = frame_sent_reg;
    assign tx_underrun = underrun_reg;

    always_ff @(posedge clk_8) begin
        if (reset_8) begin
            state_reg      <= IDLE;
            pre_cnt_reg    <= 3'd0;
            fcs_idx_reg    <= 2'd0;
            byte_cnt_reg   <= 11'd0;
            ifg_cnt_reg    <= 16'd0;
            crc_reg        <= 32'd0;
            txd_reg        <= 8'h00;
            tx_en_reg      <= 1'b0;
            tx_er_reg      <= 1'b0;
            frame_sent_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            txd_reg        <= 8'h00;
            tx_en_reg      <= 1'b0;
            tx_er_reg      <= 1'b0;
            frame_sent_reg <= 1'b0;
            underrun_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    pre_cnt_reg  <= 3'd0;
                    byte_cnt_reg <= 11'd0;
                    ifg_cnt_reg  <= 16'd0;
                    if (axis_tvalid_in) begin
                        state_reg <= PRE;
                    end
                end

                PRE: begin
                    txd_reg   <= 8'h55;
                    tx_en_reg <= 1'b1;
                    if (pre_cnt_reg == PRE_LAST) begin
                        state_reg <= SFD;
                    end else begin
                        pre_cnt_reg <= pre_cnt_reg + 3'd1;
                    end
                end

                SFD: begin
                    txd_reg      <= 8'hD5;
                    tx_en_reg    <= 1'b1;
                    crc_reg      <= CRC_INIT;
                    byte_cnt_reg <= 11'd0;
                    fcs_idx_reg  <= 2'd0;
                    state_reg    <= DATA;
                end

                DATA: begin
                    if (axis_tvalid_in) begin
                        txd_reg      <= axis_tdata_in;
                        tx_en_reg    <= 1'b1;
                        crc_reg      <= crc_next;
                        byte_cnt_reg <= cnt_inc;
                        if (axis_tlast_in) begin
                            state_reg <= (cnt_inc < MIN_LEN) ? PAD : FCS;
                        end
                    end else begin
                        // source starved mid-frame: poison the frame on the wire
                        txd_reg      <= 8'h00;
                        tx_en_reg    <= 1'b1;
                        tx_er_reg    <= 1'b1;
                        underrun_reg <= 1'b1;
                        state_reg    <= DRAIN;
                    end
                end

                PAD: begin
                    txd_reg      <= 8'h00;
                    tx_en_reg    <= 1'b1;
                    crc_reg      <= crc_next;
                    byte_cnt_reg <= cnt_inc;
                    if (cnt_inc >= MIN_LEN) begin
                        state_reg <= FCS;
                    end
                end

                FCS: begin
                    // shift the CRC down so the low byte is always the next one out
                    txd_reg   <= ~crc_reg[7:0];
                    tx_en_reg <= 1'b1;
                    crc_reg   <= {8'h00, crc_reg[31:8]};
                    if (fcs_idx_reg == 2'd3) begin
                        frame_sent_reg <= 1'b1;
                        ifg_cnt_reg    <= 16'd0;
                        state_reg      <= IFG;
                    end else begin
                        fcs_idx_reg <= fcs_idx_reg + 2'd1;
                    end
                end

                DRAIN: begin
                    if (axis_tvalid_in && axis_tlast_in) begin
                        ifg_cnt_reg <= 16'd0;
                        state_reg   <= IFG;
                    end
                end

                IFG: begin
                    if (ifg_cnt_reg >= IFG_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        ifg_cnt_reg <= ifg_cnt_reg + 16'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: random payloads driven through a ready/valid source, wire
// bytes captured by a monitor and compared against frames built from the Ethernet rules.
module tb_gmii_tx_framer;

    localparam int MIN_P = 60;

    logic       clk_8 = 1'b0;
    logic       reset_8;
    logic [7:0] axis_tdata_in;
    logic       axis_tvalid_in;
    logic       axis_tlast_in;
    logic       axis_tready_out;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       frame_sent;
    logic       tx_underrun;

    always #5 clk_8 = ~clk_8;

    gmii_tx_framer #(.MIN_PAYLOAD(60), .IFG_CYCLES(12)) dut (
        .clk_8          (clk_8),
        .reset_8        (reset_8),
        .axis_tdata_in  (axis_tdata_in),
        .axis_tvalid_in (axis_tvalid_in),
        .axis_tlast_in  (axis_tlast_in),
        .axis_tready_out(axis_tready_out),
        .gmii_txd       (gmii_txd),
        .gmii_tx_en     (gmii_tx_en),
        .gmii_tx_er     (gmii_tx_er),
        .frame_sent     (frame_sent),
        .tx_underrun    (tx_underrun)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] pay [0:4095];
    logic [7:0] exp_q[$];

    // wire monitor
    logic [7:0] cur_q[$];
    logic [7:0] last_frame[$];
    int  frames_done = 0;
    int  fs_total = 0, ur_total = 0, er_total = 0, hs_total = 0;
    int  fs_pos_last = -1, er_pos_last = -1;
    int  low_run = 0, last_gap = -1;
    bit  prev_en = 1'b0;

    always @(negedge clk_8) begin
        if (gmii_tx_en === 1'b1) begin
            if (!prev_en) begin
                last_gap = low_run;
                cur_q.delete();
            end
            cur_q.push_back(gmii_txd);
        end else begin
            if (prev_en) begin
                last_frame = cur_q;
                frames_done++;
                low_run = 0;
            end
            low_run++;
        end
        if (frame_sent === 1'b1) begin
            fs_total++;
            fs_pos_last = cur_q.size();
        end
        if (tx_underrun === 1'b1) ur_total++;
        if (gmii_tx_er === 1'b1) begin
            er_total++;
            er_pos_last = cur_q.size();
        end
        prev_en = (gmii_tx_en === 1'b1);
    end

    // handshake counter, sampled after the driver has settled its inputs
    always @(negedge clk_8) begin
        #1;
        if (axis_tvalid_in === 1'b1 && axis_tready_out === 1'b1) hs_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // non-reflected MSB-first CRC fed with LSB-first data bits
    function automatic logic [31:0] crc_msb(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic build_expected(input int n);
        logic [31:0] c;
        logic [31:0] fcs;
        int body;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        body = (n > MIN_P) ? n : MIN_P;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < body; i++) begin
            logic [7:0] b;
            b = (i < n) ? pay[i] : 8'h00;
            exp_q.push_back(b);
            c = crc_msb(c, b);
        end
        fcs = ~bitrev32(c);
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
    endtask

    task automatic compare_exp(input string tag);
        check($sformatf("%s_len", tag), last_frame.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < last_frame.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), last_frame[i], exp_q[i]);
    endtask

    task automatic check_frame(input string tag, input int n);
        logic [31:0] c;
        build_expected(n);
        compare_exp(tag);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < last_frame.size(); i++) c = crc_msb(c, last_frame[i]);
        check($sformatf("%s_residue", tag), c, 32'hC704DD7B);
        check($sformatf("%s_fs_pos", tag), fs_pos_last, exp_q.size());
    endtask

    task automatic drive_frame(input int n, input int drop_at, input int stop_at);
        int acc = 0;
        int cyc = 0;
        bit dropped = 1'b0;
        while (acc < n) begin
            @(negedge clk_8);
            if (stop_at >= 0 && acc == stop_at) return;
            cyc++;
            if (cyc > 20000) begin
                checks++;
                failures++;
                $error("FAIL drive_timeout: observed accepted=%0d expected=%0d", acc, n);
                return;
            end
            if (drop_at >= 0 && acc == drop_at && !dropped && axis_tready_out) begin
                axis_tvalid_in = 1'b0;
                axis_tlast_in  = 1'b0;
                dropped = 1'b1;
            end else begin
                axis_tvalid_in = 1'b1;
                axis_tdata_in  = pay[acc];
                axis_tlast_in  = (acc == n - 1);
                if (axis_tready_out) acc++;
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk_8);
        axis_tvalid_in = 1'b0;
        axis_tlast_in  = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int cyc = 0;
        while (frames_done < target) begin
            @(negedge clk_8);
            cyc++;
            if (cyc > 4000) begin
                checks++;
                failures++;
                $error("FAIL wait_frame: observed frames=%0d expected=%0d", frames_done, target);
                return;
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic fill_ramp(input int n);
        for (int i = 0; i < n; i++) pay[i] = 8'(i);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_txd"}, gmii_txd, 8'h00);
        check({tag, "_tx_en"}, gmii_tx_en, 1'b0);
        check({tag, "_tx_er"}, gmii_tx_er, 1'b0);
        check({tag, "_frame_sent"}, frame_sent, 1'b0);
        check({tag, "_tx_underrun"}, tx_underrun, 1'b0);
        check({tag, "_tready"}, axis_tready_out, 1'b0);
    endtask

    initial begin
        int fs0, ur0, er0, hs0, fd0, n;

        reset_8        = 1'b1;
        axis_tdata_in  = 8'h00;
        axis_tvalid_in = 1'b0;
        axis_tlast_in  = 1'b0;
        repeat (3) @(negedge clk_8);
        check_idle_outputs("reset");
        reset_8 = 1'b0;
        repeat (2) @(negedge clk_8);

        // 64-byte ramp frame
        fill_ramp(64);
        fs0 = fs_total; hs0 = hs_total; fd0 = frames_done;
        drive_frame(64, -1, -1);
        go_idle();
        wait_frames(fd0 + 1);
        check_frame("f64", 64);
        check("f64_frame_sent", fs_total - fs0, 1);
        check("f64_handshakes", hs_total - hs0, 64);

        // 10-byte frame, padded
        fill_random(10);
        fs0 = fs_total; hs0 = hs_total; fd0 = frames_done;
        drive_frame(10, -1, -1);
        go_idle();
        wait_frames(fd0 + 1);
        check_frame("f10", 10);
        check("f10_handshakes", hs_total - hs0, 10);
        check("f10_frame_sent", fs_total - fs0, 1);

        // 1-byte frame
        fill_random(1);
        fd0 = frames_done;
        drive_frame(1, -1, -1);
        go_idle();
        wait_frames(fd0 + 1);
        check_frame("f1", 1);

        // back-to-back 64-byte frames, tvalid held high across the gap
        fill_random(64);
        fs0 = fs_total; fd0 = frames_done;
        drive_frame(64, -1, -1);
        drive_frame(64, -1, -1);
        go_idle();
        wait_frames(fd0 + 2);
        check_frame("b2b", 64);
        check("b2b_gap", last_gap, 12);
        check("b2b_frame_sent", fs_total - fs0, 2);

        // underrun after byte 20 of 40
        fill_random(40);
        fs0 = fs_total; ur0 = ur_total; er0 = er_total; hs0 = hs_total; fd0 = frames_done;
        drive_frame(40, 20, -1);
        go_idle();
        wait_frames(fd0 + 1);
        repeat (20) @(negedge clk_8);
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 20; i++) exp_q.push_back(pay[i]);
        exp_q.push_back(8'h00);
        compare_exp("urun");
        check("urun_pulse", ur_total - ur0, 1);
        check("urun_er_count", er_total - er0, 1);
        check("urun_er_pos", er_pos_last, 29);
        check("urun_no_frame_sent", fs_total - fs0, 0);
        check("urun_handshakes", hs_total - hs0, 40);
        check("urun_frames", frames_done - fd0, 1);

        // randomized frames
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 130);
            fill_random(n);
            fs0 = fs_total; hs0 = hs_total; fd0 = frames_done;
            drive_frame(n, -1, -1);
            go_idle();
            wait_frames(fd0 + 1);
            check_frame($sformatf("rnd%0d_n%0d", t, n), n);
            check($sformatf("rnd%0d_handshakes", t), hs_total - hs0, n);
            check($sformatf("rnd%0d_frame_sent", t), fs_total - fs0, 1);
        end

        // over-length frame saturating the byte counter
        fill_random(2060);
        fd0 = frames_done;
        drive_frame(2060, -1, -1);
        go_idle();
        wait_frames(fd0 + 1);
        check_frame("long", 2060);

        // reset asserted after 30 bytes of a 64-byte frame
        fill_ramp(64);
        er0 = er_total; fs0 = fs_total; fd0 = frames_done;
        drive_frame(64, -1, 30);
        reset_8        = 1'b1;
        axis_tvalid_in = 1'b0;
        axis_tlast_in  = 1'b0;
        @(negedge clk_8);
        check_idle_outputs("midrst");
        reset_8 = 1'b0;
        wait_frames(fd0 + 1);
        check("midrst_trunc_len", last_frame.size(), 38);
        check("midrst_no_er", er_total - er0, 0);
        check("midrst_no_fs", fs_total - fs0, 0);

        fs0 = fs_total; fd0 = frames_done;
        drive_frame(64, -1, -1);
        go_idle();
        wait_frames(fd0 + 1);
        check_frame("after_rst", 64);
        check("after_rst_frame_sent", fs_total - fs0, 1);

        repeat (20) @(negedge clk_8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
